key_event_unit: RTL
===================

Name: key_event_unit

Overview:
- Sits directly downstream of the 12-key serial keypad interface and consumes its parallel 12-bit key vector (tipka).
- Normalises key polarity and debounces each key independently.
- Turns every debounced press and release into a 5-bit event: key index plus press/release flag.
- Buffers events in a small FWFT FIFO with a valid/ready handshake, so the rest of the design reads key events rather than polling levels.

Parameters:
- SAMPLE_DIV, 1024: clocks between debounce sample ticks; must be >= 16.
- DEB_COUNT, 4: number of consecutive differing samples needed to flip a key's stable state; range 1..15.
- DEPTH, 8: FIFO depth in events; power of 2, >= 2.
- ACTIVE_LOW, 1: 1 = a raw tipka bit of 0 means pressed; 0 = a raw bit of 1 means pressed.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- tipka  in  12  raw key vector from the keypad interface, in the clk domain.
- key_ready  in  1  consumer accepts the head event this cycle.
- ovf_clr  in  1  clears the overflow flag.
- key_valid  out  1  FIFO not empty.
- key_code  out  4  head event key index, 0..11.
- key_press  out  1  head event type: 1 = press, 0 = release.
- key_state  out  12  debounced level per key; 1 = pressed.
- fifo_level  out  clog2(DEPTH)+1  number of queued events.
- overflow  out  1  sticky flag: an event was lost.

Behaviour:
- Reset (asynchronous, rst_n=0): tick counter=0, all debounce counters=0, key_state=0, pending=0, FIFO empty, key_valid=0, key_code=0, key_press=0, fifo_level=0, overflow=0.
- Normalisation: n = ACTIVE_LOW ? ~tipka : tipka.
- Tick generation:
  - A free-running counter counts 0..SAMPLE_DIV-1 and wraps.
  - tick=1 for one clock when the counter equals SAMPLE_DIV-1.
- Debounce, per key i, evaluated only on tick:
  - If n[i]==key_state[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments. When the incremented value equals DEB_COUNT, the key flips on that same tick: key_state[i] <= n[i], cnt[i] <= 0, pending[i] <= 1.
  - A glitch shorter than DEB_COUNT ticks produces no event.
  - Between ticks, counters and key_state hold.
- Event serialiser:
  - Each clock, if pending != 0, take the lowest set index j.
  - Attempt to push {key_state[j], j} and clear pending[j], whether or not the push succeeds.
  - At most one push per clock; 12 simultaneous flips drain in 12 clocks, before the next tick (SAMPLE_DIV >= 16).
  - If key j flips again before its pending bit drains, the pending bit stays set. Only one event is pushed, carrying the current key_state[j].
- FIFO:
  - First-word-fall-through: key_valid = (level != 0); key_code/key_press are combinational from the head entry.
  - Pop occurs when key_valid && key_ready. key_ready while empty has no effect.
  - Push succeeds if level < DEPTH, or if level == DEPTH and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow <= 1.
  - Simultaneous push and pop leave the level unchanged.
  - Pointers wrap modulo DEPTH; level saturates in 0..DEPTH.
- Overflow:
  - Sticky.
  - ovf_clr=1 clears it, except when a drop occurs in the same cycle, in which case it is set (set wins).
- Latency:
  - Raw change stable from tick k is committed to key_state at tick k+DEB_COUNT-1.
  - The event appears on key_valid 2 clocks later at the earliest (pending register, then FIFO write), assuming no earlier-indexed keys are pending.
- Handshake: key_code and key_press are stable while key_valid=1 and key_ready=0.
- Reset mid-operation: all state, including queued events and pending bits, is discarded immediately.

Test Plan:
- Reset, tipka=12'hFFF held (ACTIVE_LOW=1), 20 ticks -> key_valid=0, key_state=0, overflow=0.
- tipka=12'hFFB (key 2 pressed) held for DEB_COUNT ticks, key_ready=1 -> one event key_code=2, key_press=1, key_state=12'h004. Then 12'hFFF for 4 ticks -> event code=2, press=0.
- Key 5 low for 3 ticks, then high (DEB_COUNT=4) -> no event, key_state stays 0.
- tipka=12'h000 (all pressed) held 4 ticks, key_ready=0 -> 8 events queued, codes 0..7 in order, fifo_level=8, overflow=1, codes 8..11 lost. Pulse ovf_clr -> overflow=0. Then key_ready=1 -> codes 0..7 drain with press=1 in order.
- FIFO full with key_ready=1 in the same cycle as a new push -> push accepted, level stays DEPTH, overflow stays 0.
- rst_n asserted with 3 events queued -> key_valid=0 and fifo_level=0 immediately. After release, with tipka unchanged and keys still pressed, the keys re-debounce and new press events are generated.

Source files
------------

// File: rtl/key_event_unit.sv
// Key event unit: polarity-normalises and debounces a 12-key vector, turns each
// debounced press/release into a 5-bit event and queues it in a FWFT FIFO.
module key_event_unit #(
    parameter int SAMPLE_DIV = 1024,
    parameter int DEB_COUNT  = 4,
    parameter int DEPTH      = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [11:0]              tipka,
    input  logic                     key_ready,
    input  logic                     ovf_clr,
    output logic                     key_valid,
    output logic [3:0]               key_code,
    output logic                     key_press,
    output logic [11:0]              key_state,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int                 DIV_W     = $clog2(SAMPLE_DIV);
    localparam int                 PTR_W     = $clog2(DEPTH);
    localparam int                 LVL_W     = PTR_W + 1;
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]         DEB_LIMIT = 4'(DEB_COUNT);
    localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(DEPTH);

    // Lowest set index of a 12-bit request vector; 0 when none is set.
    function automatic logic [3:0] lowest_idx(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [11:0]      norm_s;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [3:0]       cnt_r [12];
    logic [11:0]      flip_s;
    logic [11:0]      pending_r;
    logic [11:0]      pending_nxt_s;
    logic             push_s;
    logic [3:0]       sel_s;
    logic [4:0]       push_data_s;
    logic [4:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             pop_s;
    logic             wr_en_s;
    logic             drop_s;

    assign norm_s = ACTIVE_LOW ? ~tipka : tipka;
    assign tick_s = (div_r == DIV_LAST);

    // Free-running sample divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // A key flips on the tick where its run of differing samples reaches DEB_COUNT.
    always_comb begin
        flip_s = 12'h000;
        for (int i = 0; i < 12; i++) begin
            if (tick_s && (norm_s[i] != key_state[i]) && ((cnt_r[i] + 4'd1) == DEB_LIMIT)) begin
                flip_s[i] = 1'b1;
            end else begin
                flip_s[i] = 1'b0;
            end
        end
    end

    // Per-key debounce counters and stable state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++) begin
                cnt_r[i] <= 4'd0;
            end
            key_state <= 12'h000;
        end else if (tick_s) begin
            for (int i = 0; i < 12; i++) begin
                if (norm_s[i] == key_state[i]) begin
                    cnt_r[i] <= 4'd0;
                end else if (flip_s[i]) begin
                    cnt_r[i]     <= 4'd0;
                    key_state[i] <= norm_s[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + 4'd1;
                end
            end
        end else begin
            key_state <= key_state;
        end
    end

    // Serialiser: one pending key per clock, lowest index first; a fresh flip keeps its bit set.
    always_comb begin
        push_s        = |pending_r;
        sel_s         = lowest_idx(pending_r);
        push_data_s   = {key_state[sel_s], sel_s};
        pending_nxt_s = pending_r;
        if (push_s) begin
            pending_nxt_s[sel_s] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        pending_nxt_s = pending_nxt_s | flip_s;
    end

    // Pending-event register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 12'h000;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign key_valid = (fifo_level != '0);
    assign pop_s     = key_valid && key_ready;
    assign wr_en_s   = push_s && ((fifo_level != LVL_FULL) || pop_s);
    assign drop_s    = push_s && !wr_en_s;
    assign key_code  = mem_r[rd_ptr_r][3:0];
    assign key_press = mem_r[rd_ptr_r][4];

    // FIFO storage and pointers; storage is cleared so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 5'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy count; simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_level <= '0;
        end else begin
            case ({wr_en_s, pop_s})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

endmodule
